dplca_txop_table: RTL
=====================

Name: dplca_txop_table

Overview:
- Builds and ages the DPLCA TXOP claim table from observed PLCA bus activity.
- Produces the table-update strobe, new-age indication, TXOP ID/count summary and the 256x2-bit packed claim table consumed by the DPLCA node-ID/coordinator state machine.
- Sits between the PLCA control/data detection logic (TXOP boundaries, BEACON detection) and that state machine.

Parameters:
- AGING_CYCLES, 16, number of BEACON cycles per aging window (legal range 1..31).
- AGE_CNT_W, 5, width of the aging-cycle counter.

Ports:
- clk  input  1  block clock.
- plca_reset  input  1  asynchronous, active-high reset.
- dplca_en  input  1  DPLCA enable; low forces DISABLED and clears all state synchronously.
- dplca_aging  input  1  aging enable from node-ID state machine (OFF=0, ON=1).
- beacon  input  1  one-clock pulse at start of each received or transmitted BEACON.
- txop_end  input  1  one-clock pulse at end of each TXOP.
- txop_id  input  8  ID of the TXOP ending; valid with txop_end.
- txop_busy  input  1  TXOP carried a transmission (CRS seen, not COMMIT-only yield); valid with txop_end.
- dplca_txop_table_upd  output  1  one-clock strobe: table updated for the completed cycle.
- dplca_new_age  output  1  level: an aging step was applied at the last update.
- dplca_txop_id  output  8  ID of most recent TXOP in the current cycle.
- dplca_txop_node_count  output  8  TXOPs observed in the last complete cycle.
- txop_claim_table_unpacked  output  512  entry n at bits [2n+1:2n].

Behaviour:
- Entry encoding: 2'b00 FREE, 2'b01 SOFT_CLAIMED, 2'b10 HARD_CLAIMED; 2'b11 never driven.
- Internal state: 256-bit seen[] vector, age_cnt[AGE_CNT_W-1:0], max_id[7:0], any_txop flag.
- Reset (async, plca_reset=1): state DISABLED; all outputs 0; table all FREE; seen, age_cnt, max_id cleared.
- DISABLED:
  - Outputs held at reset values.
  - dplca_en=1 -> SYNC.
- SYNC:
  - Waits for the first beacon; txop_end ignored.
  - beacon -> CYCLE; max_id, any_txop and dplca_txop_id cleared.
- CYCLE, on txop_end:
  - dplca_txop_id <= txop_id.
  - max_id <= max(max_id, txop_id); any_txop <= 1.
  - If txop_busy: table[txop_id] <= HARD and seen[txop_id] <= 1 (visible the clock after txop_end).
  - First txop_end after an UPDATE clears dplca_new_age.
- CYCLE, on beacon -> UPDATE next clock.
- UPDATE (exactly one clock):
  - dplca_txop_table_upd=1.
  - dplca_txop_node_count <= any_txop ? min(max_id+1, 255) : 0.
  - If dplca_aging=1 and age_cnt==AGING_CYCLES-1:
    - Per entry: seen -> HARD; else HARD -> SOFT; else SOFT -> FREE.
    - seen cleared; age_cnt <= 0; dplca_new_age <= 1.
  - Else if dplca_aging=1: age_cnt <= age_cnt+1; table unchanged.
  - If dplca_aging=0: age_cnt held at 0, dplca_new_age <= 0.
  - max_id, any_txop and dplca_txop_id cleared; -> CYCLE.
- Latency:
  - beacon at clock k -> upd high at clock k+1.
  - Aged table visible at clock k+2, concurrently with dplca_new_age.
- Simultaneous events:
  - txop_end and beacon in the same clock: the TXOP is recorded in the ending cycle before UPDATE.
  - beacon during UPDATE is ignored.
  - txop_end during UPDATE is processed as CYCLE (counts toward the new cycle).
- dplca_aging falling mid-window: age_cnt cleared at next UPDATE; table retained.
- dplca_en=0 or plca_reset mid-cycle: immediate return to DISABLED with full clear; no upd strobe issued.
- txop_id=255 busy: entry 255 claimed; node_count saturates at 255.

Test Plan:
- Reset then dplca_en=1, beacon, TXOPs 0..7 with 0,3 busy, beacon -> upd one clock at k+1; node_count=8; entries 0,3=HARD, others FREE; new_age=0.
- AGING_CYCLES=2, dplca_aging=1, node 3 busy in cycle 1 only:
  - After update 2: entry 3 stays HARD, new_age=1.
  - After update 4: entry 3 = SOFT.
  - After update 6: entry 3 = FREE.
  - new_age clears on first txop_end after each aging update.
- txop_end(id=5, busy) coincident with beacon -> entry 5 HARD; node_count=6; upd the following clock.
- TXOP id 255 busy -> entry 255 = bits[511:510] = 2'b10; node_count=255.
- Mid-cycle plca_reset pulse, and separately dplca_en=0 -> no upd; all outputs 0; table FREE; block needs a new beacon from SYNC before recording.
- dplca_aging=0 over 40 cycles -> new_age never asserts; claimed entries remain HARD.

Source files
------------

// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim table: records busy TXOPs per BEACON cycle and ages claims
// HARD -> SOFT -> FREE over a window of AGING_CYCLES cycles.
module dplca_txop_table #(
  parameter int unsigned AGING_CYCLES = 16,
  parameter int unsigned AGE_CNT_W    = 5
) (
  input  logic         clk,
  input  logic         plca_reset,
  input  logic         dplca_en,
  input  logic         dplca_aging,
  input  logic         beacon,
  input  logic         txop_end,
  input  logic [7:0]   txop_id,
  input  logic         txop_busy,
  output logic         dplca_txop_table_upd,
  output logic         dplca_new_age,
  output logic [7:0]   dplca_txop_id,
  output logic [7:0]   dplca_txop_node_count,
  output logic [511:0] txop_claim_table_unpacked
);

  localparam logic [1:0] Free = 2'b00;
  localparam logic [1:0] Soft = 2'b01;
  localparam logic [1:0] Hard = 2'b10;

  typedef enum logic [1:0] {StDisabled, StSync, StCycle, StUpdate} state_e;

  state_e               state;
  logic [255:0]         seen;
  logic [AGE_CNT_W-1:0] age_cnt;
  logic [7:0]           max_id;
  logic                 any_txop;

  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      state                     <= StDisabled;
      seen                      <= '0;
      age_cnt                   <= '0;
      max_id                    <= '0;
      any_txop                  <= 1'b0;
      dplca_txop_table_upd      <= 1'b0;
      dplca_new_age             <= 1'b0;
      dplca_txop_id             <= '0;
      dplca_txop_node_count     <= '0;
      txop_claim_table_unpacked <= '0;
    end else if (!dplca_en) begin
      state                     <= StDisabled;
      seen                      <= '0;
      age_cnt                   <= '0;
      max_id                    <= '0;
      any_txop                  <= 1'b0;
      dplca_txop_table_upd      <= 1'b0;
      dplca_new_age             <= 1'b0;
      dplca_txop_id             <= '0;
      dplca_txop_node_count     <= '0;
      txop_claim_table_unpacked <= '0;
    end else begin
      case (state)
        StDisabled: state <= StSync;
        StSync: begin
          if (beacon) begin
            state         <= StCycle;
            max_id        <= '0;
            any_txop      <= 1'b0;
            dplca_txop_id <= '0;
          end
        end
        StCycle, StUpdate: begin
          if (state == StUpdate) begin
            dplca_txop_table_upd  <= 1'b0;
            dplca_txop_node_count <= !any_txop ? 8'd0 :
                                     (max_id == 8'hff) ? 8'hff : max_id + 8'd1;
            if (dplca_aging) begin
              if (age_cnt == AGE_CNT_W'(AGING_CYCLES - 1)) begin
                for (int i = 0; i < 256; i++) begin
                  if (seen[i]) begin
                    txop_claim_table_unpacked[2*i +: 2] <= Hard;
                  end else if (txop_claim_table_unpacked[2*i +: 2] == Hard) begin
                    txop_claim_table_unpacked[2*i +: 2] <= Soft;
                  end else begin
                    txop_claim_table_unpacked[2*i +: 2] <= Free;
                  end
                end
                seen          <= '0;
                age_cnt       <= '0;
                dplca_new_age <= 1'b1;
              end else begin
                age_cnt <= age_cnt + 1'b1;
              end
            end else begin
              age_cnt       <= '0;
              dplca_new_age <= 1'b0;
            end
            max_id        <= '0;
            any_txop      <= 1'b0;
            dplca_txop_id <= '0;
            state         <= StCycle;
          end else if (beacon) begin
            state                <= StUpdate;
            dplca_txop_table_upd <= 1'b1;
          end
          // A TXOP ending during UPDATE belongs to the new cycle, so it overrides
          // the per-cycle clears and the aging result for its own entry.
          if (txop_end) begin
            dplca_txop_id <= txop_id;
            any_txop      <= 1'b1;
            if (state == StUpdate || txop_id > max_id) begin
              max_id <= txop_id;
            end
            if (state == StCycle) begin
              dplca_new_age <= 1'b0;
            end
            if (txop_busy) begin
              txop_claim_table_unpacked[{txop_id, 1'b0} +: 2] <= Hard;
              seen[txop_id]                                  <= 1'b1;
            end
          end
        end
        default: state <= StDisabled;
      endcase
    end
  end

endmodule
